// File: rtl/fft_peak_finder.sv
// Sweeps a range of FFT output bins over the slave read port, tracks the bin with the
// largest L1 magnitude and reports it, with a threshold detect flag, on a done pulse.
module fft_peak_finder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int FIRST_BIN  = 1,
    parameter int LAST_BIN   = 15,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH:0]     threshold,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_re,
    input  logic [2*DATA_WIDTH-1:0] s_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   peak_bin,
    output logic [DATA_WIDTH:0]     peak_mag,
    output logic                    detect
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_BIN);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_BIN);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic                  s_re_q, s_re_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] peak_bin_q, peak_bin_d;
    logic [DATA_WIDTH:0]   peak_mag_q, peak_mag_d;
    logic                  detect_q, detect_d;
    logic [DATA_WIDTH:0]   thr_q, thr_d;
    logic [DATA_WIDTH:0]   max_mag_q, max_mag_d;
    logic [ADDR_WIDTH-1:0] max_bin_q, max_bin_d;
    logic                  have_max_q, have_max_d;
    logic [RD_LAT-1:0]     vld_pipe_q, vld_pipe_d;
    logic [ADDR_WIDTH-1:0] tag_pipe_q [RD_LAT];
    logic [ADDR_WIDTH-1:0] tag_pipe_d [RD_LAT];

    logic [DATA_WIDTH-1:0] re_raw, im_raw, re_abs, im_abs;
    logic [DATA_WIDTH:0]   mag, cand_mag;
    logic [ADDR_WIDTH-1:0] tail_tag, cand_bin;
    logic                  tail_vld, take;

    // abs() of the most negative value wraps to exactly 2**(DATA_WIDTH-1) as unsigned
    always_comb begin
        re_raw   = s_data[2*DATA_WIDTH-1:DATA_WIDTH];
        im_raw   = s_data[DATA_WIDTH-1:0];
        re_abs   = re_raw[DATA_WIDTH-1] ? (~re_raw + DATA_WIDTH'(1)) : re_raw;
        im_abs   = im_raw[DATA_WIDTH-1] ? (~im_raw + DATA_WIDTH'(1)) : im_raw;
        mag      = {1'b0, re_abs} + {1'b0, im_abs};
        tail_vld = vld_pipe_q[RD_LAT-1];
        tail_tag = tag_pipe_q[RD_LAT-1];
        take     = tail_vld && (!have_max_q || mag > max_mag_q);
        cand_mag = take ? mag : max_mag_q;
        cand_bin = take ? tail_tag : max_bin_q;
    end

    always_comb begin
        state_d    = state_q;
        s_addr_d   = s_addr_q;
        s_re_d     = s_re_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        detect_d   = detect_q;
        thr_d      = thr_q;
        max_mag_d  = cand_mag;
        max_bin_d  = cand_bin;
        have_max_d = have_max_q | tail_vld;

        vld_pipe_d[0] = s_re_q;
        tag_pipe_d[0] = s_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    thr_d      = threshold;
                    s_addr_d   = FIRST_ADDR;
                    s_re_d     = 1'b1;
                    busy_d     = 1'b1;
                    have_max_d = 1'b0;
                    max_mag_d  = '0;
                    max_bin_d  = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // stop on LAST_ADDR itself so an all-ones last bin never wraps into a stray read
                if (s_addr_q == LAST_ADDR) begin
                    s_re_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    s_addr_d = s_addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (tail_vld && tail_tag == LAST_ADDR) begin
                    peak_bin_d = cand_bin;
                    peak_mag_d = cand_mag;
                    detect_d   = (cand_mag >= thr_q);
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_addr_q   <= '0;
            s_re_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
            detect_q   <= 1'b0;
            thr_q      <= '0;
            max_mag_q  <= '0;
            max_bin_q  <= '0;
            have_max_q <= 1'b0;
            vld_pipe_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            s_addr_q   <= s_addr_d;
            s_re_q     <= s_re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            detect_q   <= detect_d;
            thr_q      <= thr_d;
            max_mag_q  <= max_mag_d;
            max_bin_q  <= max_bin_d;
            have_max_q <= have_max_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    assign s_addr   = s_addr_q;
    assign s_re     = s_re_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign peak_bin = peak_bin_q;
    assign peak_mag = peak_mag_q;
    assign detect   = detect_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: three instances (RD_LAT 1, RD_LAT 3, single bin 31 with RD_LAT 2)
// share one bin memory; each has its own delayed read model that returns garbage when not reading.
module tb_fft_peak_finder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v    [3];
    logic [16:0] thr_v      [3];
    logic [4:0]  s_addr_v   [3];
    logic        s_re_v     [3];
    logic [31:0] s_data_v   [3];
    logic        busy_v     [3];
    logic        done_v     [3];
    logic [4:0]  peak_bin_v [3];
    logic [16:0] peak_mag_v [3];
    logic        detect_v   [3];

    logic [31:0] mem     [32];
    logic [31:0] rd_pipe [3][4];

    int first_bin [3] = '{1, 1, 31};
    int last_bin  [3] = '{15, 15, 31};
    int rd_lat    [3] = '{1, 3, 2};

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int bin_a; int re_a; int im_a;
        int bin_b; int re_b; int im_b;
        int thr;
        int exp_bin; int exp_mag; bit exp_det;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    fft_peak_finder #(.RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .threshold(thr_v[0]),
        .s_addr(s_addr_v[0]), .s_re(s_re_v[0]), .s_data(s_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .peak_bin(peak_bin_v[0]),
        .peak_mag(peak_mag_v[0]), .detect(detect_v[0])
    );

    fft_peak_finder #(.RD_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .threshold(thr_v[1]),
        .s_addr(s_addr_v[1]), .s_re(s_re_v[1]), .s_data(s_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .peak_bin(peak_bin_v[1]),
        .peak_mag(peak_mag_v[1]), .detect(detect_v[1])
    );

    fft_peak_finder #(.FIRST_BIN(31), .LAST_BIN(31), .RD_LAT(2)) u_dut_edge (
        .clk(clk), .rst(rst), .start(start_v[2]), .threshold(thr_v[2]),
        .s_addr(s_addr_v[2]), .s_re(s_re_v[2]), .s_data(s_data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .peak_bin(peak_bin_v[2]),
        .peak_mag(peak_mag_v[2]), .detect(detect_v[2])
    );

    // slave port model: data appears rd_lat cycles after the read, random junk otherwise
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            rd_pipe[d][0] <= s_re_v[d] ? mem[s_addr_v[d]] : $urandom;
            for (int i = 1; i < 4; i++) rd_pipe[d][i] <= rd_pipe[d][i-1];
        end
    end
    assign s_data_v[0] = rd_pipe[0][0];
    assign s_data_v[1] = rd_pipe[1][2];
    assign s_data_v[2] = rd_pipe[2][1];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: scan bins in order, strictly larger magnitude replaces the current peak
    function automatic void ref_peak(input int first, input int last, input logic [16:0] thr,
                                     output int pb, output int pm, output bit det);
        int re, im, m;
        pm = -1;
        pb = 0;
        for (int b = first; b <= last; b++) begin
            re = $signed(mem[b][31:16]);
            im = $signed(mem[b][15:0]);
            m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
            if (m > pm) begin
                pm = m;
                pb = b;
            end
        end
        det = (pm >= int'(thr));
    endfunction

    task automatic load_vec(input vec_t v);
        for (int b = 0; b < 32; b++) mem[b] = '0;
        mem[v.bin_b] = {16'(v.re_b), 16'(v.im_b)};
        mem[v.bin_a] = {16'(v.re_a), 16'(v.im_a)};
    endtask

    task automatic apply_stimulus(input int idx, input logic [16:0] thr, input int extra_j,
                                  input int exp_bin, input int exp_mag, input bit exp_det,
                                  input string tag);
        int nb, done_j, window, re_cnt, addr_bad, done_cnt, done_at, busy_bad;
        logic [4:0]  got_bin;
        logic [16:0] got_mag;
        logic        got_det;
        nb       = last_bin[idx] - first_bin[idx] + 1;
        done_j   = nb + rd_lat[idx] + 1;
        window   = done_j + 8;
        re_cnt   = 0;
        addr_bad = 0;
        done_cnt = 0;
        done_at  = -1;
        busy_bad = 0;
        got_bin  = '0;
        got_mag  = '0;
        got_det  = 1'b0;
        @(negedge clk);
        start_v[idx] = 1'b1;
        thr_v[idx]   = thr;
        for (int j = 1; j <= window; j++) begin
            @(negedge clk);
            start_v[idx] = (j == extra_j);
            thr_v[idx]   = 17'($urandom);
            if (s_re_v[idx]) begin
                re_cnt++;
                if (j > nb || int'(s_addr_v[idx]) != first_bin[idx] + j - 1) addr_bad++;
            end
            if (done_v[idx]) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (busy_v[idx] !== (j < done_j)) busy_bad++;
            if (j == done_j) begin
                got_bin = peak_bin_v[idx];
                got_mag = peak_mag_v[idx];
                got_det = detect_v[idx];
            end
        end
        check_output({tag, "/s_re_cycles"}, re_cnt, nb);
        check_output({tag, "/s_addr_seq_errors"}, addr_bad, 0);
        check_output({tag, "/done_cycle"}, done_at, done_j);
        check_output({tag, "/done_count"}, done_cnt, 1);
        check_output({tag, "/busy_shape_errors"}, busy_bad, 0);
        check_output({tag, "/peak_bin"}, got_bin, exp_bin);
        check_output({tag, "/peak_mag"}, got_mag, exp_mag);
        check_output({tag, "/detect"}, got_det, exp_det);
        check_output({tag, "/peak_mag_held"}, peak_mag_v[idx], exp_mag);
    endtask

    task automatic check_reset_state(input int idx, input string tag);
        check_output(tag, {s_re_v[idx], busy_v[idx], done_v[idx], detect_v[idx],
                           s_addr_v[idx], peak_bin_v[idx], peak_mag_v[idx]}, 0);
    endtask

    initial begin
        int pb, pm;
        bit det;
        logic [16:0] thr;
        int re_cnt, done_cnt;

        vecs[0] = '{5, 100, -50, 0, 30000, 30000, 100, 5, 150, 1};
        vecs[1] = '{3, 30, -10, 9, -20, 20, 41, 3, 40, 0};
        vecs[2] = '{7, -32768, -32768, 0, 0, 0, 65536, 7, 65536, 1};
        vecs[3] = '{4, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        vecs[4] = '{12, -7, 3, 2, 5, 4, 10, 12, 10, 1};
        vecs[5] = '{15, 0, -51, 14, 50, 0, 200, 15, 51, 0};

        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            thr_v[d]   = '0;
        end
        for (int b = 0; b < 32; b++) mem[b] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_reset_state(d, $sformatf("reset_state/dut%0d", d));
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            for (int d = 0; d < 2; d++) begin
                apply_stimulus(d, 17'(vecs[v].thr), 0, vecs[v].exp_bin, vecs[v].exp_mag,
                               vecs[v].exp_det, $sformatf("table%0d/lat%0d", v, rd_lat[d]));
            end
        end

        // extra start 4 cycles in, then a start landing in the FINISH cycle
        load_vec(vecs[0]);
        apply_stimulus(0, 17'd100, 4, 5, 150, 1, "start_busy/lat1");
        apply_stimulus(1, 17'd100, 4, 5, 150, 1, "start_busy/lat3");
        apply_stimulus(0, 17'd100, 17, 5, 150, 1, "start_finish/lat1");
        apply_stimulus(1, 17'd100, 19, 5, 150, 1, "start_finish/lat3");

        // reset in cycle k+6 of a sweep, then a clean sweep
        @(negedge clk);
        start_v[0] = 1'b1;
        thr_v[0]   = 17'd100;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, "mid_reset/outputs_after_rst");
        re_cnt   = 0;
        done_cnt = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (s_re_v[0]) re_cnt++;
            if (done_v[0]) done_cnt++;
        end
        check_output("mid_reset/no_reads_after", re_cnt, 0);
        check_output("mid_reset/no_done_after", done_cnt, 0);
        apply_stimulus(0, 17'd100, 0, 5, 150, 1, "mid_reset/fresh_sweep");

        for (int it = 0; it < 18; it++) begin
            int idx;
            idx = it % 3;
            for (int b = 0; b < 32; b++) begin
                if (it % 4 == 1) begin
                    mem[b][31:16] = 16'(int'($urandom_range(0, 6)) - 3);
                    mem[b][15:0]  = 16'(int'($urandom_range(0, 6)) - 3);
                end else if (it % 4 == 2) begin
                    mem[b] = ($urandom_range(0, 3) == 0) ? 32'h8000_8000 : $urandom;
                end else begin
                    mem[b] = $urandom;
                end
            end
            thr = (it % 2 == 0) ? 17'($urandom) : 17'($urandom_range(0, 12));
            ref_peak(first_bin[idx], last_bin[idx], thr, pb, pm, det);
            apply_stimulus(idx, thr, 0, pb, pm, det, $sformatf("random%0d/dut%0d", it, idx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
